i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50: 7-bit address this target answers to.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer depth on i2c_scl and i2c_sda_i, with a minimum of 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: system clock; rising edge is active.
REQ-005 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port i2c_scl, input, 1 bit: bus clock from the controller; asynchronous to clk.
REQ-007 Port i2c_sda_i, input, 1 bit: resolved SDA line level.
REQ-008 Port i2c_sda_o, output, 1 bit: open-drain drive; 0 pulls the line low, 1 releases it.
REQ-009 Port rx_data, output, 8 bits: last byte received in a write transfer.
REQ-010 Port rx_valid, output, 1 bit: one-clk pulse when rx_data updates.
REQ-011 Port tx_data, input, 8 bits: byte to send in a read transfer; sampled when tx_req is high.
REQ-012 Port tx_req, output, 1 bit: one-clk pulse requesting tx_data.
REQ-013 Port busy, output, 1 bit: high from an address match until STOP.

Function
REQ-014 Operating condition: clk frequency SHALL be at least 8x the SCL frequency; all bus sampling SHALL use the synchronized signals.
REQ-015 START SHALL be detected as a synchronized SDA falling edge while synchronized SCL is high.
REQ-016 STOP SHALL be detected as a synchronized SDA rising edge while synchronized SCL is high.
REQ-017 SDA SHALL be sampled on the synchronized SCL rising edge.
REQ-018 SDA drive SHALL change only on the clk cycle after a synchronized SCL falling edge.
REQ-019 FSM states: IDLE, ADDR, ACK_ADDR, RX, ACK_RX, TX, ACK_TX, IGNORE.
REQ-020 IDLE -> ADDR on START; the 3-bit bit counter SHALL clear.
REQ-021 ADDR: shift 8 bits MSB first (7 address bits, then R/W).
REQ-022 On the 8th bit, a match SHALL go to ACK_ADDR; a mismatch SHALL go to IGNORE.
REQ-023 ACK_ADDR: drive SDA low for exactly one SCL high period.
REQ-024 ACK_ADDR exit: R/W=0 -> RX; R/W=1 -> TX, with tx_req pulsed on entry and tx_data loaded into the shift register.
REQ-025 RX: after 8 bits, rx_data SHALL update and rx_valid SHALL pulse in the same cycle; then go to ACK_RX.
REQ-026 ACK_RX: drive SDA low for one bit, then return to RX.
REQ-027 TX: drive the shift register MSB first for 8 bits, then go to ACK_TX with SDA released.
REQ-028 ACK_TX: sample the controller ACK. ACK (0) -> pulse tx_req, reload, go to TX. NACK (1) -> IGNORE.
REQ-029 IGNORE: SDA released; wait for START or STOP.
REQ-030 STOP in any state SHALL go to IDLE, release SDA and deassert busy within 1 clk.
REQ-031 START in any non-IDLE state (repeated start) SHALL go to ADDR with the counter cleared; busy holds until the next address compare.
REQ-032 START or STOP mid-byte SHALL discard the partial byte; rx_valid SHALL NOT pulse.
REQ-033 The bit counter SHALL wrap 7 -> 0 at each byte boundary; transfer length is unlimited.
REQ-034 Only START and STOP may change state during the SCL high phase.

Reset
REQ-035 reset_n low SHALL asynchronously force the FSM to IDLE with the following output values: i2c_sda_o = 1, rx_data = 8'h00, rx_valid = 0, tx_req = 0, busy = 0.
REQ-036 Reset SHALL preset the synchronizers to 1 (idle bus).
REQ-037 After reset release, the block SHALL respond only to a fresh START.

Structure
REQ-038 Package i2c_pkg SHALL hold the slave state enum and the ACK/NACK level constants; the controller block shares this package.
REQ-039 Sub-module i2c_sync_edge SHALL implement the SYNC_STAGES synchronizer plus rise/fall pulses; it is instantiated once for SCL and once for SDA.
REQ-040 The FSM, shift register and counter SHALL live in i2c_slave.

Verification
REQ-041 Write transfer: START, 0xA0, 0x3C, 0x81, STOP -> ACK on all three bytes; rx_valid pulses twice, with rx_data 0x3C then 0x81; busy falls after STOP.
REQ-042 Read transfer: START, 0xA1; tx_data=0x5A then 0xC3; controller ACKs then NACKs -> SDA carries 0x5A then 0xC3; tx_req pulses twice; after the NACK, SDA is released.
REQ-043 Address mismatch: START, 0x90 -> SDA stays 1 throughout the ACK bit; no rx_valid; busy stays 0.
REQ-044 Repeated start: START, 0xA0, 4 data bits, START, 0xA1 -> partial byte dropped; read proceeds normally.
REQ-045 Mid-transfer reset: reset_n low during an ACK_RX low drive -> i2c_sda_o = 1 immediately; outputs at reset values; the next write transfer is accepted normally.
REQ-046 STOP mid-byte: after 3 bits of a write byte -> IDLE; no rx_valid; SDA released.

Source files
------------

// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C state encoding and bus level constants
// Used by both the target (slave) and controller blocks.

package i2c_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ACK_ADDR = 3'd2,
    ST_RX       = 3'd3,
    ST_ACK_RX   = 3'd4,
    ST_TX       = 3'd5,
    ST_ACK_TX   = 3'd6,
    ST_IGNORE   = 3'd7
  } slave_state_e;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_sync_edge.sv
// rtl/i2c_sync_edge.sv - multi-stage synchronizer with rise/fall pulses
// Presets to 1 so an idle bus produces no edge when reset releases.

module i2c_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;
  logic         prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[N-2:0], async_i};
      prev_q <= sync_q[N-1];
    end
  end

  assign level_o = sync_q[N-1];
  assign rise_o  = sync_q[N-1] & ~prev_q;
  assign fall_o  = ~sync_q[N-1] & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - 7-bit address I2C target with byte receive/transmit
// State moves on SCL falling edges only, except START/STOP which act at once.

module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_scl,
  input  logic       i2c_sda_i,
  output logic       i2c_sda_o,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det, addr_match;

  slave_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         byte_done_q, byte_done_d;
  logic [7:0]   shift_q, shift_d;
  logic         ack_q, ack_d;
  logic         sda_q, sda_d;
  logic [7:0]   rx_data_q, rx_data_d;
  logic         rx_valid_q, rx_valid_d;
  logic         busy_q, busy_d;

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (i2c_scl),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .async_i (i2c_sda_i),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_det  = sda_fall & scl_lvl;
  assign stop_det   = sda_rise & scl_lvl;
  assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (stop_det) begin
      state_d = ST_IDLE;
    end else if (start_det) begin
      state_d = ST_ADDR;
    end else if (scl_fall) begin
      case (state_q)
        ST_ADDR:     if (byte_done_q) state_d = addr_match ? ST_ACK_ADDR : ST_IGNORE;
        ST_ACK_ADDR: state_d = shift_q[0] ? ST_TX : ST_RX;
        ST_RX:       if (byte_done_q) state_d = ST_ACK_RX;
        ST_ACK_RX:   state_d = ST_RX;
        ST_TX:       if (byte_done_q) state_d = ST_ACK_TX;
        ST_ACK_TX:   state_d = (ack_q == I2C_ACK) ? ST_TX : ST_IGNORE;
        default:     state_d = state_q;
      endcase
    end
  end

  // Drive values are computed here and registered on the fall-detect edge,
  // so SDA moves exactly one clk after each synchronized SCL fall.
  always_comb begin
    cnt_d       = cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    ack_d       = ack_q;
    sda_d       = sda_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    tx_req      = 1'b0;
    if (stop_det) begin
      sda_d       = 1'b1;
      busy_d      = 1'b0;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
    end else if (start_det) begin
      sda_d       = 1'b1;
      cnt_d       = 3'd0;
      byte_done_d = 1'b0;
    end else begin
      if (scl_rise) begin
        case (state_q)
          ST_ADDR, ST_RX: begin
            shift_d = {shift_q[6:0], sda_lvl};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              byte_done_d = 1'b1;
              if (state_q == ST_RX) begin
                rx_data_d  = {shift_q[6:0], sda_lvl};
                rx_valid_d = 1'b1;
              end
            end
          end
          ST_TX: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) byte_done_d = 1'b1;
          end
          ST_ACK_TX: ack_d = sda_lvl;
          default: ;
        endcase
      end
      if (scl_fall) begin
        case (state_q)
          ST_ADDR: begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              busy_d      = addr_match;
              sda_d       = addr_match ? I2C_ACK : I2C_NACK;
            end
          end
          ST_ACK_ADDR: begin
            if (shift_q[0]) begin
              tx_req  = 1'b1;
              shift_d = tx_data;
              sda_d   = tx_data[7];
            end else begin
              sda_d = 1'b1;
            end
          end
          ST_RX: begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_d       = I2C_ACK;
            end
          end
          ST_ACK_RX: sda_d = 1'b1;
          ST_TX: begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_d       = 1'b1;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sda_d   = shift_q[6];
            end
          end
          ST_ACK_TX: begin
            if (ack_q == I2C_ACK) begin
              tx_req  = 1'b1;
              shift_d = tx_data;
              sda_d   = tx_data[7];
            end else begin
              sda_d = 1'b1;
            end
          end
          default: sda_d = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      ack_q       <= I2C_NACK;
      sda_q       <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      ack_q       <= ack_d;
      sda_q       <= sda_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign i2c_sda_o = sda_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - directed bench for i2c_slave driving a modelled controller
// Bus is a wired-AND of controller and target drives; SCL runs at 1/20 of clk.

module tb_i2c_slave;

  localparam int Q = 50;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_line = 1'b1;
  logic       ctrl_sda = 1'b1;
  logic       sda_bus;
  logic       sda_o;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       busy;

  int         n_tests = 0;
  int         n_fail = 0;
  int         rx_cnt = 0;
  int         tx_cnt = 0;
  int         viol_cnt = 0;
  logic       low_seen = 1'b0;
  logic       sda_prev = 1'b1;
  logic [7:0] rx_log [0:15];

  assign sda_bus = ctrl_sda & sda_o;

  i2c_slave #(.SLAVE_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i2c_scl   (scl_line),
    .i2c_sda_i (sda_bus),
    .i2c_sda_o (sda_o),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_cnt < 16) rx_log[rx_cnt] = rx_data;
      rx_cnt = rx_cnt + 1;
    end
    if (tx_req) tx_cnt = tx_cnt + 1;
    if (sda_o === 1'b0) low_seen = 1'b1;
    if (reset_n && scl_line && (sda_o !== sda_prev)) viol_cnt = viol_cnt + 1;
    sda_prev = sda_o;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_start();
    if (!scl_line) begin
      #Q ctrl_sda = 1'b1;
      #Q scl_line = 1'b1;
    end
    #Q ctrl_sda = 1'b0;
    #Q scl_line = 1'b0;
  endtask

  task automatic bus_stop();
    #Q ctrl_sda = 1'b0;
    #Q scl_line = 1'b1;
    #Q ctrl_sda = 1'b1;
    #Q;
  endtask

  task automatic send_bit(input logic b, output logic r);
    #Q ctrl_sda = b;
    #Q scl_line = 1'b1;
    #Q r = sda_bus;
    #Q scl_line = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) send_bit(d[i], r);
    send_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack_bit, input logic [7:0] next_tx, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, r);
      d[i] = r;
      if (i == 7) tx_data = next_tx;
    end
    send_bit(ack_bit, r);
  endtask

  initial begin
    logic       a;
    logic       r;
    logic [7:0] d;
    logic [7:0] pat;

    // Reset state
    #50;
    chk("rst_sda", 32'(sda_o), 32'h1);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'h0);
    chk("rst_tx_req", 32'(tx_req), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    #50 reset_n = 1'b1;
    #100;
    chk("idle_busy", 32'(busy), 32'h0);

    // Write transfer
    bus_start();
    send_byte(8'hA0, a);
    chk("wr_addr_ack", 32'(a), 32'h0);
    chk("wr_busy", 32'(busy), 32'h1);
    send_byte(8'h3C, a);
    chk("wr_b0_ack", 32'(a), 32'h0);
    send_byte(8'h81, a);
    chk("wr_b1_ack", 32'(a), 32'h0);
    bus_stop();
    #100;
    chk("wr_rx_cnt", 32'(rx_cnt), 32'd2);
    chk("wr_rx0", 32'(rx_log[0]), 32'h3C);
    chk("wr_rx1", 32'(rx_log[1]), 32'h81);
    chk("wr_rx_data", 32'(rx_data), 32'h81);
    chk("wr_busy_stop", 32'(busy), 32'h0);

    // Read transfer: ACK first byte, NACK second
    tx_data = 8'h5A;
    bus_start();
    send_byte(8'hA1, a);
    chk("rd_addr_ack", 32'(a), 32'h0);
    recv_byte(1'b0, 8'hC3, d);
    chk("rd_b0", 32'(d), 32'h5A);
    recv_byte(1'b1, 8'hEE, d);
    chk("rd_b1", 32'(d), 32'hC3);
    #(2*Q);
    chk("rd_nack_release", 32'(sda_o), 32'h1);
    chk("rd_tx_cnt", 32'(tx_cnt), 32'd2);
    bus_stop();
    #100;
    chk("rd_busy_stop", 32'(busy), 32'h0);
    chk("rd_no_rx", 32'(rx_cnt), 32'd2);

    // Address mismatch
    low_seen = 1'b0;
    bus_start();
    send_byte(8'h90, a);
    chk("mm_ack_bit", 32'(a), 32'h1);
    chk("mm_no_drive", 32'(low_seen), 32'h0);
    chk("mm_busy", 32'(busy), 32'h0);
    bus_stop();
    #100;
    chk("mm_no_rx", 32'(rx_cnt), 32'd2);

    // Repeated start after a partial write byte
    tx_data = 8'h96;
    bus_start();
    send_byte(8'hA0, a);
    chk("rs_addr_ack", 32'(a), 32'h0);
    pat = 8'hB0;
    for (int i = 7; i >= 4; i--) send_bit(pat[i], r);
    bus_start();
    #100;
    chk("rs_busy_hold", 32'(busy), 32'h1);
    send_byte(8'hA1, a);
    chk("rs_rd_ack", 32'(a), 32'h0);
    recv_byte(1'b1, 8'h00, d);
    chk("rs_rd_data", 32'(d), 32'h96);
    chk("rs_tx_cnt", 32'(tx_cnt), 32'd3);
    bus_stop();
    #100;
    chk("rs_no_rx", 32'(rx_cnt), 32'd2);
    chk("rs_busy_stop", 32'(busy), 32'h0);

    // STOP after 3 bits of a write byte
    bus_start();
    send_byte(8'hA0, a);
    chk("sm_addr_ack", 32'(a), 32'h0);
    pat = 8'hA0;
    for (int i = 7; i >= 5; i--) send_bit(pat[i], r);
    bus_stop();
    #100;
    chk("sm_no_rx", 32'(rx_cnt), 32'd2);
    chk("sm_sda", 32'(sda_o), 32'h1);
    chk("sm_busy", 32'(busy), 32'h0);

    // Reset while the target drives the data-byte ACK low
    bus_start();
    send_byte(8'hA0, a);
    chk("rr_addr_ack", 32'(a), 32'h0);
    pat = 8'h3C;
    for (int i = 7; i >= 0; i--) send_bit(pat[i], r);
    #Q;
    chk("rr_ack_drive", 32'(sda_o), 32'h0);
    chk("rr_rx_cnt", 32'(rx_cnt), 32'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("rr_sda", 32'(sda_o), 32'h1);
    chk("rr_rx_data", 32'(rx_data), 32'h00);
    chk("rr_rx_valid", 32'(rx_valid), 32'h0);
    chk("rr_tx_req", 32'(tx_req), 32'h0);
    chk("rr_busy", 32'(busy), 32'h0);
    #(Q-2);
    ctrl_sda = 1'b1;
    #Q scl_line = 1'b1;
    #Q reset_n = 1'b1;
    #(2*Q);
    chk("rr_idle_busy", 32'(busy), 32'h0);
    bus_start();
    send_byte(8'hA0, a);
    chk("rr_wr_addr_ack", 32'(a), 32'h0);
    send_byte(8'h55, a);
    chk("rr_wr_ack", 32'(a), 32'h0);
    bus_stop();
    #100;
    chk("rr_wr_cnt", 32'(rx_cnt), 32'd4);
    chk("rr_wr_data", 32'(rx_log[3]), 32'h55);
    chk("rr_wr_busy", 32'(busy), 32'h0);

    chk("sda_high_phase_changes", 32'(viol_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
